// File: rtl/i2f_block_sequencer.sv
// Feeds 8x8 pixel blocks through an external 1-cycle int8->float converter,
// issuing only against output-FIFO credits, and streams floats downstream.
module i2f_block_sequencer #(
    parameter int BLK_SIZE    = 64,
    parameter int FIFO_DEPTH  = 4,
    parameter bit LEVEL_SHIFT = 1'b1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  cvt_din,
    output logic        cvt_din_valid,
    input  logic [31:0] cvt_dout,
    input  logic        cvt_dout_valid,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        blk_done,
    output logic        busy,
    output logic        err
);

    localparam int CW = $clog2(BLK_SIZE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BLK_SIZE - 1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(FIFO_DEPTH - 1);
    localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);
    localparam logic [NW:0]   DEPTH_EXT = (NW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          inflight;
    logic          inflight_last;
    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [NW-1:0] fifo_cnt;
    logic [NW:0]   credits_used;
    logic          accept;
    logic          blk_end;
    logic          pop;
    logic          push;
    logic          fifo_full;

    // Credits count converter results already in flight; pops free nothing
    // until the next cycle so the converter can never outrun the FIFO.
    assign credits_used = {1'b0, fifo_cnt} + {{NW{1'b0}}, inflight};
    assign pix_ready    = nrst & (state != DRAIN) & (credits_used < DEPTH_EXT);
    assign accept       = pix_valid & pix_ready;
    assign blk_end      = accept & (cnt == CNT_LAST);

    assign cvt_din_valid = accept;
    assign cvt_din = !nrst       ? 8'h00 :
                     LEVEL_SHIFT ? {~pix_in[7], pix_in[6:0]} : pix_in;

    assign out_valid           = fifo_cnt != '0;
    assign {out_last, out_data} = mem[rd_ptr];
    assign pop                 = out_valid & out_ready;
    assign fifo_full           = fifo_cnt == DEPTH_N;
    assign push                = cvt_dout_valid & (~fifo_full | pop);
    assign busy                = (state != IDLE) | out_valid;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            cnt           <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            blk_done      <= 1'b0;
            err           <= 1'b0;
        end else begin
            inflight      <= accept;
            inflight_last <= blk_end;
            blk_done      <= pop & out_last;
            if (accept)
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            if (cvt_dout_valid & fifo_full & ~pop)
                err <= 1'b1;
            unique case (state)
                IDLE:    if (accept) state <= blk_end ? DRAIN : RUN;
                RUN:     if (blk_end) state <= DRAIN;
                DRAIN:   if (pop & out_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {inflight_last, cvt_dout};
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
            if (push & ~pop)
                fifo_cnt <= fifo_cnt + NW'(1);
            else if (pop & ~push)
                fifo_cnt <= fifo_cnt - NW'(1);
        end
    end

endmodule

// File: tb/tb_i2f_block_sequencer.sv
// Bench for i2f_block_sequencer: behavioural converter, scoreboard queue of
// expected {last, float} pushed on accept and popped on each output handshake.
module tb_i2f_block_sequencer;

    logic        clk;
    logic        nrst;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  cvt_din;
    logic        cvt_din_valid;
    logic [31:0] cvt_dout;
    logic        cvt_dout_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        blk_done;
    logic        busy;
    logic        err;

    logic        conv_valid;
    logic [31:0] conv_dout;
    logic        force_dv;
    logic        rnd_ready;

    int n_checks = 0;
    int n_fail = 0;
    int n_acc = 0;
    int n_pop = 0;
    int n_last = 0;
    int n_done = 0;
    int cyc = 0;
    int tb_cnt = 0;
    logic [32:0] exp_q[$];
    int pop_cyc[$];

    i2f_block_sequencer dut (
        .clk(clk), .nrst(nrst),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .cvt_din(cvt_din), .cvt_din_valid(cvt_din_valid),
        .cvt_dout(cvt_dout), .cvt_dout_valid(cvt_dout_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .blk_done(blk_done), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] i2f(input logic [7:0] v);
        logic        s;
        logic [7:0]  m;
        logic [31:0] t;
        int          e;
        if (v == 8'h00) return 32'h0;
        s = v[7];
        m = s ? 8'(-v) : v;
        e = 7;
        while (!m[e]) e--;
        t = 32'(m) << (23 - e);
        return {s, 8'(127 + e), t[22:0]};
    endfunction

    // External converter: fixed 1-cycle latency, shares the reset.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            conv_valid <= 1'b0;
            conv_dout  <= 32'h0;
        end else begin
            conv_valid <= cvt_din_valid;
            conv_dout  <= i2f(cvt_din);
        end
    end
    assign cvt_dout_valid = conv_valid | force_dv;
    assign cvt_dout       = conv_dout;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Monitor: scoreboard, blk_done timing and hold-under-stall checks.
    initial begin
        logic        exp_done;
        logic        stall;
        logic [32:0] held;
        logic [32:0] want;
        exp_done = 1'b0;
        stall = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!nrst) begin
                exp_done = 1'b0;
                stall = 1'b0;
            end else begin
                check("blk_done", 64'(blk_done), 64'(exp_done));
                if (stall) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_data", 64'({out_last, out_data}), 64'(held));
                end
                exp_done = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("sb_empty", 64'(exp_q.size()), 64'd1);
                    end else begin
                        want = exp_q.pop_front();
                        check("sb_data", 64'({out_last, out_data}), 64'(want));
                    end
                    n_pop++;
                    if (out_last) n_last++;
                    exp_done = out_last;
                    pop_cyc.push_back(cyc);
                end
                stall = out_valid & ~out_ready;
                held = {out_last, out_data};
                if (pix_valid && pix_ready) begin
                    exp_q.push_back({tb_cnt == 63, i2f(8'(pix_in - 8'd128))});
                    tb_cnt = (tb_cnt + 1) % 64;
                    n_acc++;
                end
                if (blk_done) n_done++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom % 4) != 0;
    endtask

    task automatic send(input logic [7:0] p);
        int w;
        w = 0;
        pix_in = p;
        pix_valid = 1'b1;
        @(negedge clk);
        while (!pix_ready && w < 300) begin
            tick();
            @(negedge clk);
            w++;
        end
        check("send_ready", 64'(pix_ready), 64'd1);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (busy && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("idle_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        tick();
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        pix_valid = 1'b0;
        #1;
        check("rst_flags", 64'({out_valid, out_last, pix_ready, cvt_din_valid,
                               blk_done, busy, err}), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        exp_q.delete();
        tb_cnt = 0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0]  sp_pix [4];
        logic [31:0] sp_exp [4];
        int b_pop, b_last, b_done, b_acc;
        sp_pix = '{8'h80, 8'h81, 8'h00, 8'hFF};
        sp_exp = '{32'h0000_0000, 32'h3F80_0000, 32'hC300_0000, 32'h42FE_0000};

        nrst = 1'b0;
        pix_in = 8'h00;
        pix_valid = 1'b0;
        out_ready = 1'b1;
        force_dv = 1'b0;
        rnd_ready = 1'b0;
        #3;
        check("init_flags", 64'({out_valid, out_last, pix_ready, cvt_din_valid,
                                blk_done, busy, err}), 64'd0);
        check("init_data", 64'(out_data), 64'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        tick();
        @(negedge clk);
        check("post_rst_ready", 64'(pix_ready), 64'd1);
        tick();

        // single pixels: result appears two cycles after accept
        for (int i = 0; i < 4; i++) begin
            pix_in = sp_pix[i];
            pix_valid = 1'b1;
            @(negedge clk);
            check("sp_ready", 64'(pix_ready), 64'd1);
            tick();
            pix_valid = 1'b0;
            @(negedge clk);
            check("sp_lat1", 64'(out_valid), 64'd0);
            @(negedge clk);
            check("sp_lat2", 64'(out_valid), 64'd1);
            check("sp_data", 64'(out_data), 64'(sp_exp[i]));
            tick();
        end
        do_reset();

        // full block back-to-back
        b_pop = n_pop; b_last = n_last; b_done = n_done;
        for (int i = 0; i < 64; i++) send(8'($urandom));
        @(negedge clk);
        check("drain_ready", 64'(pix_ready), 64'd0);
        wait_idle();
        check("blk_pops", 64'(n_pop - b_pop), 64'd64);
        check("blk_last", 64'(n_last - b_last), 64'd1);
        check("blk_done_cnt", 64'(n_done - b_done), 64'd1);
        check("blk_span", 64'(pop_cyc[pop_cyc.size() - 1] - pop_cyc[b_pop]), 64'd63);
        check("blk_idle_ready", 64'(pix_ready), 64'd1);

        // backpressure from sample 3
        b_acc = n_acc; b_done = n_done;
        send(8'h11);
        send(8'h22);
        out_ready = 1'b0;
        pix_in = 8'h33;
        pix_valid = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        #1;
        check("bp_accepts", 64'(n_acc - b_acc), 64'd4);
        check("bp_ready", 64'(pix_ready), 64'd0);
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_err", 64'(err), 64'd0);
        tick();
        out_ready = 1'b1;
        pix_valid = 1'b0;
        for (int i = 4; i < 64; i++) send(8'(i * 7));
        wait_idle();
        check("bp_done", 64'(n_done - b_done), 64'd1);
        check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        // random valid/ready over three blocks
        b_pop = n_pop; b_last = n_last; b_done = n_done;
        rnd_ready = 1'b1;
        for (int i = 0; i < 192; i++) begin
            repeat ($urandom % 3) tick();
            send(8'($urandom));
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        check("rnd_pops", 64'(n_pop - b_pop), 64'd192);
        check("rnd_last", 64'(n_last - b_last), 64'd3);
        check("rnd_done", 64'(n_done - b_done), 64'd3);
        check("rnd_sb_empty", 64'(exp_q.size()), 64'd0);

        // reset mid-block, then a clean block
        for (int i = 0; i < 30; i++) send(8'(i + 100));
        do_reset();
        b_last = n_last; b_done = n_done;
        for (int i = 0; i < 64; i++) send(8'($urandom));
        wait_idle();
        check("postrst_last", 64'(n_last - b_last), 64'd1);
        check("postrst_done", 64'(n_done - b_done), 64'd1);

        // forced converter write into a full FIFO
        out_ready = 1'b0;
        pix_in = 8'h5A;
        pix_valid = 1'b1;
        repeat (6) tick();
        pix_valid = 1'b0;
        @(negedge clk);
        #1;
        check("ovf_full_ready", 64'(pix_ready), 64'd0);
        check("ovf_err_pre", 64'(err), 64'd0);
        tick();
        force_dv = 1'b1;
        tick();
        force_dv = 1'b0;
        @(negedge clk);
        check("ovf_err_set", 64'(err), 64'd1);
        tick();
        out_ready = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        check("ovf_err_sticky", 64'(err), 64'd1);
        check("ovf_drained", 64'(out_valid), 64'd0);
        check("ovf_sb_empty", 64'(exp_q.size()), 64'd0);
        tick();
        do_reset();
        @(negedge clk);
        check("ovf_err_clr", 64'(err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
